// File: rtl/gate_vector_tester.sv
// Sequencer that applies every input combination to NUM_GATES identical gates of an IC,
// waits a settle time per vector, samples the outputs and reports per-gate and overall results.
module gate_vector_tester #(
    parameter int NUM_GATES     = 4,
    parameter int GATE_INPUTS   = 2,
    parameter int SETTLE_CYCLES = 12500005
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [2:0]                       gate_sel,
    input  logic                             icg,
    input  logic [NUM_GATES-1:0]             sense,
    output logic [NUM_GATES*GATE_INPUTS-1:0] drive,
    output logic                             busy,
    output logic                             done,
    output logic [NUM_GATES-1:0]             gate_pass,
    output logic [NUM_GATES-1:0]             gate_fail,
    output logic                             pass,
    output logic                             fail,
    output logic [1:0]                       state_dbg
);

    // Handshake: start is a level sampled only in IDLE (icg must be high); busy stays high
    // from the accepting edge until the DONE edge, where done pulses for exactly one cycle and
    // the result outputs become valid and hold until the next accepted start, icg low or reset.

    localparam int NUM_VEC = 2 ** GATE_INPUTS;
    localparam int V_W     = GATE_INPUTS + 1;
    localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [V_W-1:0]   LAST_VEC = V_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state;
    logic [2:0]             sel_q;
    logic [V_W-1:0]         vec;
    logic [V_W-1:0]         vec_next;
    logic [CNT_W-1:0]       cnt;
    logic [NUM_GATES-1:0]   mism;
    logic [NUM_GATES-1:0]   sample_mism;
    logic                   exp_bit;

    function automatic logic expected_out(input logic [2:0] sel,
                                          input logic [GATE_INPUTS-1:0] v);
        logic r;
        r = 1'b0;
        case (sel)
            3'b000:  r = &v;
            3'b001:  r = |v;
            3'b010:  r = ~&v;
            3'b011:  r = ~|v;
            3'b100:  r = ^v;
            3'b101:  r = ~^v;
            3'b110:  r = ~v[0];
            default: r = v[0];
        endcase
        return r;
    endfunction

    always_comb begin
        exp_bit     = expected_out(sel_q, vec[GATE_INPUTS-1:0]);
        sample_mism = sense ^ {NUM_GATES{exp_bit}};
        vec_next    = vec + V_W'(1);
    end

    assign state_dbg = state;

    // icg low is treated exactly like reset: an IC pulled mid-run leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst_n || !icg) begin
            state     <= S_IDLE;
            sel_q     <= 3'b000;
            vec       <= '0;
            cnt       <= '0;
            mism      <= '0;
            drive     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            gate_pass <= '0;
            gate_fail <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    drive <= '0;
                    if (start) begin
                        sel_q     <= gate_sel;
                        vec       <= '0;
                        mism      <= '0;
                        gate_pass <= '0;
                        gate_fail <= '0;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        cnt       <= CNT_LOAD;
                        busy      <= 1'b1;
                        state     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    drive <= {NUM_GATES{vec[GATE_INPUTS-1:0]}};
                    if (cnt == '0) begin
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    mism <= mism | sample_mism;
                    if (vec == LAST_VEC) begin
                        state <= S_DONE;
                    end else begin
                        // Present the next vector on this edge so it gets the full settle window.
                        vec   <= vec_next;
                        drive <= {NUM_GATES{vec_next[GATE_INPUTS-1:0]}};
                        cnt   <= CNT_LOAD;
                        state <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    gate_fail <= mism;
                    gate_pass <= ~mism;
                    pass      <= &(~mism);
                    fail      <= |mism;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    drive     <= '0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
